lfsr_long_divider: RTL and testbench
====================================

# lfsr_long_divider

Sequential restoring long divider that sits directly downstream of `lfsr1`. It consumes the 16-bit pseudo-random words `lfsr1` produces: the first accepted word is the dividend, the second is the divisor. It produces quotient and remainder one bit per cycle behind a valid/ready handshake. Results feed the bench's golden-file comparison against the Matlab model.

## Interface
- `WIDTH`, 16, operand/result width in bits; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `lfsr_in`  in  WIDTH  operand word, connected to `lfsr1.lfsr_out`.
- `in_valid`  in  1  `lfsr_in` holds a word available for capture.
- `in_ready`  out  1  block can accept a word this cycle.
- `quotient`  out  WIDTH  result quotient.
- `remainder`  out  WIDTH  result remainder.
- `div_by_zero`  out  1  result was computed with divisor 0.
- `out_valid`  out  1  result outputs are valid.
- `out_ready`  in  1  consumer accepts the result.

## Operation
- States: LOAD_A → LOAD_B → DIVIDE → DONE → LOAD_A.
- **LOAD_A:** `in_ready`=1. On `in_valid`&&`in_ready`, capture `lfsr_in` as the dividend and go to LOAD_B.
- **LOAD_B:** `in_ready`=1. On a transfer, capture the divisor, clear the remainder register (WIDTH+1 bits), load the quotient shift register with the dividend, set the iteration counter to 0, and go to DIVIDE.
- **DIVIDE:** `in_ready`=0. One iteration per cycle:
  - shift {rem, q} left by 1;
  - trial = rem_shifted − {1'b0, divisor} at WIDTH+1 bits;
  - if the trial is non-negative, rem = trial and q LSB = 1; otherwise restore and q LSB = 0.
  - After WIDTH iterations (counter = WIDTH−1 on its last cycle), go to DONE.
- **DONE:** `out_valid`=1. `quotient`, `remainder` (low WIDTH bits) and `div_by_zero` are held stable until `out_valid`&&`out_ready`, then the block returns to LOAD_A.
- **Divisor 0, feature off:** the normal iterations naturally give quotient = all ones and remainder = dividend; `div_by_zero`=1.
- `div_by_zero` is registered at divisor capture. It is valid only while `out_valid`=1 and is 0 otherwise.
- `in_valid` is ignored outside LOAD_A/LOAD_B. Words presented then are not captured; `lfsr1` free-runs and those words are simply dropped.

## Timing
- **Reset:** state = LOAD_A; `in_ready`=1 and `out_valid`=0 on the first cycle after reset; `quotient`=0, `remainder`=0, `div_by_zero`=0; all internal registers cleared.
- **Reset mid-operation:** aborts any state, including DONE with a result not yet taken, and discards the partial result. No output is produced for the aborted pair.
- **Back-to-back input:** dividend at edge E0, divisor at edge E0+1 at the earliest.
- **Latency:** the divisor is captured at edge E. DIVIDE then occupies the cycles after edges E … E+WIDTH−1, and `out_valid` rises after edge E+WIDTH (16 cycles for WIDTH=16).
- **Output release:** result accepted at edge F. `out_valid`=0 and `in_ready`=1 after edge F, so the next dividend can be captured at F+1. Minimum throughput is one result per WIDTH+3 cycles.
- **Simultaneous events:** `out_ready` may be held high permanently. `out_ready` asserted before DONE has no effect. `reset` overrides every handshake in the same cycle.

## Configuration
- `LONGDIV_ZERO_SKIP_EN` defined: in LOAD_B, a transferred word equal to 0 is discarded. The block stays in LOAD_B with `in_ready`=1 and uses the next non-zero word as the divisor. `div_by_zero` is tied to 0.
- Not defined: a zero divisor is accepted and processed as described under Operation, with `div_by_zero`=1.

## Test plan
- **Basic division:** after reset, `in_valid`=1; feed 100 then 7; `out_ready`=1. Require `quotient`=14, `remainder`=2, `div_by_zero`=0, with `out_valid` exactly 16 cycles after the divisor edge.
- **Edge values:** feed 16'hFFFF/1 → `quotient`=16'hFFFF, `remainder`=0. Feed 5/9 → `quotient`=0, `remainder`=5. Feed 16'hFFFF/16'hFFFF → `quotient`=1, `remainder`=0.
- **Zero divisor:** feed 1234, 0, 10.
  - Macro undefined: `quotient`=16'hFFFF, `remainder`=1234, `div_by_zero`=1.
  - `LONGDIV_ZERO_SKIP_EN` defined: `quotient`=123, `remainder`=4, `div_by_zero`=0.
- **Backpressure:** feed 1000/3 with `out_ready`=0 for 5 cycles after `out_valid`. Outputs must hold at 333/1 and `in_ready` must stay 0. Raise `out_ready`: `in_ready`=1 on the next cycle.
- **Reset mid-operation:** feed 50000/7 and assert `reset` for 1 cycle at the 8th DIVIDE cycle. The next cycle must show `out_valid`=0, `in_ready`=1 and zeroed outputs. A subsequent 20/6 pair gives 3/2.
- **Stream against golden model:** connect `lfsr1` with seed 2 and `out_ready`=1. Run 128 results; every quotient/remainder pair must match the Matlab golden file, with 0 mismatches reported.

Source files
------------

// File: rtl/lfsr_long_divider.sv
// lfsr_long_divider: restoring divider taking dividend then divisor words; LONGDIV_ZERO_SKIP_EN skips zero divisors
module lfsr_long_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] lfsr_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {LOAD_A, LOAD_B, DIVIDE, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_q;
  logic [WIDTH:0]   r_rem, w_sh, w_trial;
  logic [CW-1:0]    r_cnt;
  logic             r_dbz, w_zero, w_take_a, w_take_b, w_last;
  assign w_zero   = lfsr_in == '0;
  assign w_take_a = r_state == LOAD_A && in_valid;
`ifdef LONGDIV_ZERO_SKIP_EN
  assign w_take_b = r_state == LOAD_B && in_valid && !w_zero;
`else
  assign w_take_b = r_state == LOAD_B && in_valid;
`endif
  assign w_last    = r_cnt == CW'(WIDTH - 1);
  assign w_sh      = (r_rem << 1) | {{WIDTH{1'b0}}, r_q[WIDTH-1]};
  assign w_trial   = w_sh - {1'b0, r_b};
  assign quotient  = r_q;
  assign remainder = r_rem[WIDTH-1:0];
  assign div_by_zero = r_dbz & out_valid;
  // state register
  always_ff @(posedge clk)
    r_state <= reset ? LOAD_A : w_next;
  // next-state and handshake outputs
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      LOAD_A: begin
        in_ready = 1'b1;
        w_next   = in_valid ? LOAD_B : LOAD_A;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        w_next   = w_take_b ? DIVIDE : LOAD_B;
      end
      DIVIDE: w_next = w_last ? DONE : DIVIDE;
      DONE: begin
        out_valid = 1'b1;
        w_next    = out_ready ? LOAD_A : DONE;
      end
      default: w_next = LOAD_A;
    endcase
  end
  // operand capture and one restoring iteration per DIVIDE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_q   <= '0;
      r_rem <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
    end else begin
      if (w_take_a) r_a <= lfsr_in;
      if (w_take_b) begin
        r_b   <= lfsr_in;
        r_rem <= '0;
        r_q   <= r_a;
        r_cnt <= '0;
`ifdef LONGDIV_ZERO_SKIP_EN
        r_dbz <= 1'b0;
`else
        r_dbz <= w_zero;
`endif
      end
      if (r_state == DIVIDE) begin
        r_rem <= w_trial[WIDTH] ? w_sh : w_trial;
        r_q   <= {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lfsr_long_divider.sv
// tb_lfsr_long_divider: table vectors, corner sequences and an LFSR stream scored against a reference divider
module tb_lfsr_long_divider;
`ifdef LONGDIV_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  typedef struct {logic [15:0] a, b, q, r; logic z;} vec_t;
  typedef struct {logic [15:0] q, r; logic z;} res_t;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic [15:0] lfsr_in = '0;
  logic in_ready, div_by_zero, out_valid;
  logic [15:0] quotient, remainder;
  res_t sb[$];
  res_t r_exp;
  vec_t tbl[8];
  int n_chk = 0, n_pass = 0, n_res = 0;
  bit stream = 0, phase = 0;
  logic [15:0] cap_a, lfsr;

  always #5 clk = ~clk;

  lfsr_long_divider dut (
    .clk(clk), .reset(reset), .lfsr_in(lfsr_in), .in_valid(in_valid), .in_ready(in_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
    res_t t;
    t = (b == 0) ? '{q: 16'hFFFF, r: a, z: 1'b1} : '{q: a / b, r: a % b, z: 1'b0};
    return t;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      phase = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_result: got q=%0d r=%0d with none pending", quotient, remainder);
        end else begin
          r_exp = sb.pop_front();
          chk("result", {15'b0, quotient, remainder, div_by_zero}, {15'b0, r_exp.q, r_exp.r, r_exp.z});
          n_res++;
        end
      end
      if (stream && in_valid && in_ready) begin
        if (!phase) begin
          cap_a = lfsr_in;
          phase = 1;
        end else if (lfsr_in != 0 || !SKIP) begin
          sb.push_back(model(cap_a, lfsr_in));
          phase = 0;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    int k = 0;
    in_valid = 1;
    lfsr_in  = w;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    tick;
    in_valid = 0;
  endtask

  task automatic drain;
    int k = 0;
    while ((sb.size() != 0 || out_valid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k == 200) begin
      n_chk++;
      $display("FAIL drain_timeout: pending=%0d required 0", sb.size());
    end
    tick;
  endtask

  initial begin
    int k, start;
    tbl[0] = '{16'hFFFF, 16'd1,     16'hFFFF, 16'd0,   1'b0};
    tbl[1] = '{16'd5,    16'd9,     16'd0,    16'd5,   1'b0};
    tbl[2] = '{16'hFFFF, 16'hFFFF,  16'd1,    16'd0,   1'b0};
    tbl[3] = '{16'd1,    16'd1,     16'd1,    16'd0,   1'b0};
    tbl[4] = '{16'd0,    16'd5,     16'd0,    16'd0,   1'b0};
    tbl[5] = '{16'hFFFF, 16'd256,   16'd255,  16'd255, 1'b0};
    tbl[6] = '{16'd12345, 16'd123,  16'd100,  16'd45,  1'b0};
    tbl[7] = '{16'd40000, 16'd200,  16'd200,  16'd0,   1'b0};
    repeat (3) tick;
    reset = 0;
    @(negedge clk);
    chk("reset_state", {in_ready, out_valid, quotient, remainder, div_by_zero},
        {1'b1, 1'b0, 16'd0, 16'd0, 1'b0});
    tick;
    sb.push_back('{q: 16'd14, r: 16'd2, z: 1'b0});
    send(16'd100);
    send(16'd7);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) chk("divide_in_ready", {47'b0, in_ready}, 48'd0);
    end while (!out_valid && k < 40);
    chk("latency", 48'(k - 1), 48'd16);
    drain;
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{q: tbl[i].q, r: tbl[i].r, z: tbl[i].z});
      send(tbl[i].a);
      send(tbl[i].b);
      drain;
    end
    if (SKIP) sb.push_back('{q: 16'd123, r: 16'd4, z: 1'b0});
    else sb.push_back('{q: 16'hFFFF, r: 16'd1234, z: 1'b1});
    send(16'd1234);
    send(16'd0);
    if (SKIP) send(16'd10);
    drain;
    out_ready = 0;
    sb.push_back('{q: 16'd333, r: 16'd1, z: 1'b0});
    send(16'd1000);
    send(16'd3);
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("bp_hold", {14'b0, quotient, remainder, in_ready, out_valid}, {14'b0, 16'd333, 16'd1, 1'b0, 1'b1});
    repeat (4) begin
      tick;
      @(negedge clk);
      chk("bp_hold", {14'b0, quotient, remainder, in_ready, out_valid}, {14'b0, 16'd333, 16'd1, 1'b0, 1'b1});
    end
    tick;
    out_ready = 1;
    @(negedge clk);
    tick;
    @(negedge clk);
    chk("bp_release", {46'b0, in_ready, out_valid}, {46'b0, 1'b1, 1'b0});
    tick;
    send(16'd50000);
    send(16'd7);
    repeat (7) tick;
    reset = 1;
    tick;
    reset = 0;
    @(negedge clk);
    chk("abort", {13'b0, out_valid, in_ready, quotient, remainder, div_by_zero},
        {13'b0, 1'b0, 1'b1, 16'd0, 16'd0, 1'b0});
    tick;
    sb.push_back('{q: 16'd3, r: 16'd2, z: 1'b0});
    send(16'd20);
    send(16'd6);
    drain;
    start = n_res;
    lfsr = 16'd2;
    stream = 1;
    in_valid = 1;
    k = 0;
    while (n_res < start + 128 && k < 5000) begin
      lfsr_in = lfsr;
      tick;
      lfsr = lfsr_next(lfsr);
      k++;
    end
    chk("stream_results", 48'(n_res - start), 48'd128);
    stream = 0;
    in_valid = 0;
    reset = 1;
    tick;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
